sar_controller: RTL and testbench

Successive-approximation sequencer for the SAR ADC. It runs each conversion in two phases: a sample phase, then an N-bit binary search that drives the capacitive-DAC trial code and samples the comparator decision once per bit. It sits between the analog core (sample switch, cap-DAC, comparator) and the digital consumer. The analog stimuli blocks drive its `start` and `comp` inputs in simulation.

---
 rtl/sar_pkg.sv | 25 ++
 rtl/sar_timer.sv | 32 +++
 rtl/sar_controller.sv | 131 +++++++++++++
 tb/tb_sar_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared types and sizing helpers for the SAR ADC sequencer.
//   sar_state_t : FSM encoding (IDLE, SAMPLE, CONVERT, DONE)
//   *_DEF       : default resolution / timing parameters
//   cnt_w()     : cycle-counter width, $clog2(max(SAMPLE_CYC, SETTLE_CYC)), min 1
//   idx_w()     : bit-index width, $clog2(N), min 1
package sar_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} sar_state_t;

    localparam int N_DEF          = 4;
    localparam int SAMPLE_CYC_DEF = 2;
    localparam int SETTLE_CYC_DEF = 1;

    // The counter only ever holds (cycles - 1), so $clog2(max) bits suffice.
    function automatic int cnt_w(input int sample_cyc, input int settle_cyc);
        int m;
        m = (sample_cyc > settle_cyc) ? sample_cyc : settle_cyc;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_timer.sv
// sar_timer: loadable down-counter shared by sample and per-bit settle timing.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : value loaded; the interval lasts load_val+1 cycles
//   tc         : count is 0 (last cycle of the interval)
//   near       : count is 1 (next cycle is the last one)
module sar_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         near
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc   = (cnt == '0);
    assign near = (cnt == W'(1));

endmodule

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation sequencer (sample, then N-bit
// binary search driving the cap-DAC and strobing the comparator).
//   clk, rst_n : clock, async active-low reset
//   start      : conversion request (examined in IDLE and DONE only)
//   comp       : comparator decision, 1 keeps the trial bit
//   sample     : sample switch control
//   comp_en    : comparator strobe, last settle cycle of each bit
//   dac_code   : trial code to the cap-DAC
//   busy       : high in SAMPLE and CONVERT
//   eoc        : one-cycle end-of-conversion pulse
//   dout       : last completed result
module sar_controller
    import sar_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         comp,
    output logic         sample,
    output logic         comp_en,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         eoc,
    output logic [N-1:0] dout
);

    localparam int CW = cnt_w(SAMPLE_CYC, SETTLE_CYC);
    localparam int IW = idx_w(N);

    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] TOP_IDX   = IW'(N - 1);
    // With one settle cycle per bit the strobe is high in every CONVERT cycle.
    localparam logic          SETTLE1   = (SETTLE_CYC == 1);

    sar_state_t    state;
    logic [IW-1:0] idx;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_tc;
    logic          tmr_near;

    sar_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc),
        .near     (tmr_near)
    );

    // Timer reloads on every interval boundary the FSM is about to cross.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        case (state)
            IDLE, DONE: if (start) begin
                tmr_load = 1'b1;
                tmr_val  = SAMPLE_LD;
            end
            SAMPLE:  tmr_load = tmr_tc;
            CONVERT: tmr_load = tmr_tc && (idx != '0);
            default: tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sample   <= 1'b0;
            comp_en  <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            eoc      <= 1'b0;
            dout     <= '0;
        end else begin
            eoc <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= SAMPLE;
                    sample   <= 1'b1;
                    busy     <= 1'b1;
                    dac_code <= '0;
                end
                SAMPLE: if (tmr_tc) begin
                    state    <= CONVERT;
                    sample   <= 1'b0;
                    idx      <= TOP_IDX;
                    dac_code <= {1'b1, {(N-1){1'b0}}};
                    comp_en  <= SETTLE1;
                end
                CONVERT: begin
                    if (tmr_tc) begin
                        dac_code[idx] <= comp;
                        if (idx == '0) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            eoc     <= 1'b1;
                            comp_en <= 1'b0;
                            dout    <= {dac_code[N-1:1], comp};
                        end else begin
                            dac_code[idx - 1'b1] <= 1'b1;
                            idx                  <= idx - 1'b1;
                            comp_en              <= SETTLE1;
                        end
                    end else begin
                        // Strobe lands in the cycle where the timer reaches 0.
                        comp_en <= tmr_near;
                    end
                end
                DONE: begin
                    dac_code <= '0;
                    if (start) begin
                        state  <= SAMPLE;
                        sample <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: directed checks of sar_controller with default timing
// (dut) and with SETTLE_CYC=3 (dut3). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_sar_controller;

    logic       clk;
    logic       rst_n;
    logic       start, comp;
    logic       sample, comp_en, busy, eoc;
    logic [3:0] dac_code, dout;
    logic       start3, comp3;
    logic       sample3, comp_en3, busy3, eoc3;
    logic [3:0] dac_code3, dout3;

    int checks = 0;
    int errors = 0;

    sar_controller #(.N(4), .SAMPLE_CYC(2), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .comp(comp),
        .sample(sample), .comp_en(comp_en), .dac_code(dac_code),
        .busy(busy), .eoc(eoc), .dout(dout)
    );

    sar_controller #(.N(4), .SAMPLE_CYC(2), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .comp(comp3),
        .sample(sample3), .comp_en(comp_en3), .dac_code(dac_code3),
        .busy(busy3), .eoc(eoc3), .dout(dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion on dut from IDLE with a single-cycle start pulse.
    // trace holds the four dac_code values, first in [15:12].
    task automatic conv4(input string tag, input logic [3:0] cbits,
                         input logic [15:0] trace, input logic [3:0] res);
        start = 1'b1;
        step();                                   // after E0
        start = 1'b0;
        chk({tag, "_sample0"}, sample, 1);
        chk({tag, "_busy"}, busy, 1);
        step();                                   // after E1
        chk({tag, "_sample1"}, sample, 1);
        step();                                   // after E2: CONVERT
        chk({tag, "_sample_off"}, sample, 0);
        for (int b = 3; b >= 0; b--) begin
            chk($sformatf("%s_dac%0d", tag, b), dac_code, trace[b*4 +: 4]);
            chk($sformatf("%s_cen%0d", tag, b), comp_en, 1);
            chk($sformatf("%s_noeoc%0d", tag, b), eoc, 0);
            comp = cbits[b];
            step();
        end
        chk({tag, "_eoc"}, eoc, 1);               // after E6
        chk({tag, "_dout"}, dout, res);
        chk({tag, "_final_dac"}, dac_code, res);
        chk({tag, "_busy_done"}, busy, 0);
        step();                                   // back in IDLE
        chk({tag, "_eoc_off"}, eoc, 0);
        chk({tag, "_idle_dac"}, dac_code, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; comp = 1'b0; start3 = 1'b0; comp3 = 1'b0;
        step(); step();
        chk("rst_sample", sample, 0);
        chk("rst_comp_en", comp_en, 0);
        chk("rst_dac", dac_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eoc", eoc, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;
        step();
        chk("idle_no_start", busy, 0);

        conv4("basic", 4'b1011, 16'h8CAB, 4'b1011);
        conv4("all0",  4'b0000, 16'h8421, 4'b0000);
        conv4("all1",  4'b1111, 16'h8CEF, 4'b1111);

        // Back-to-back: first result 1111, second 0000.
        start = 1'b1; comp = 1'b1;
        n = 0;
        while (!eoc && n < 20) begin step(); n++; end
        chk("b2b_first_eoc", eoc, 1);
        chk("b2b_first_dout", dout, 4'hF);
        comp = 1'b0;
        n = 0;
        do begin
            step(); n++;
            if (n == 1) chk("b2b_sample_after_eoc", sample, 1);
            if (!eoc) chk("b2b_dout_hold", dout, 4'hF);
        end while (!eoc && n < 20);
        chk("b2b_period", n, 7);
        chk("b2b_second_dout", dout, 4'h0);
        start = 1'b0;
        step();
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_sample", sample, 0);

        // start dropped during CONVERT.
        start = 1'b1;
        step(); step(); step();                   // after E2: CONVERT
        start = 1'b0;
        for (int b = 3; b >= 0; b--) begin
            comp = (b == 2 || b == 0);
            step();
        end
        chk("drop_eoc", eoc, 1);
        chk("drop_dout", dout, 4'b0101);
        step();
        chk("drop_busy", busy, 0);
        chk("drop_dac", dac_code, 0);
        for (int k = 0; k < 3; k++) begin
            chk("drop_no_sample", sample, 0);
            step();
        end

        // SETTLE_CYC=3: comp inverted outside strobe cycles, result 0110.
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("s3_sample", sample3, 1);
        step(); step();                           // after E2
        for (int b = 3; b >= 0; b--) begin
            for (int c = 0; c < 3; c++) begin
                logic [3:0] bits;
                logic [15:0] tr;
                bits = 4'b0110;
                tr   = 16'h8467;
                if (c == 0) chk($sformatf("s3_dac%0d", b), dac_code3, tr[b*4 +: 4]);
                chk($sformatf("s3_cen%0d_%0d", b, c), comp_en3, (c == 2));
                chk("s3_noeoc", eoc3, 0);
                comp3 = (c == 2) ? bits[b] : ~bits[b];
                step();
            end
        end
        chk("s3_eoc_E14", eoc3, 1);
        chk("s3_dout", dout3, 4'b0110);
        step();
        chk("s3_idle_busy", busy3, 0);

        // Asynchronous reset mid-bit with dac_code=1100.
        start = 1'b1; comp = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();                   // after E3
        chk("midrst_pre_dac", dac_code, 4'b1100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dac", dac_code, 0);
        chk("midrst_sample", sample, 0);
        chk("midrst_comp_en", comp_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_eoc", eoc, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_dout3", dout3, 0);
        step();
        rst_n = 1'b1; start = 1'b1;
        chk("midrst_held_sample", sample, 0);
        step();
        start = 1'b0;
        chk("postrst_sample", sample, 1);
        chk("postrst_busy", busy, 1);
        repeat (8) step();
        chk("postrst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
